seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle signed 32-bit integer divider for the ALU/multdiv datapath. It performs the inverse of the adder path: one restoring shift/subtract step per cycle.
- Reports arithmetic exceptions (divide-by-zero, signed overflow) on a flag, mirroring how the adder path reports overflow.
- Sits beside the ALU and is started by the control unit with a one-cycle command pulse.

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement).
- ITERS, WIDTH, number of shift/subtract iterations.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ctrl_DIV  input  1  start pulse; operands are sampled on the same edge.
- data_operandA  input  WIDTH  dividend, signed.
- data_operandB  input  WIDTH  divisor, signed.
- data_result  output  WIDTH  quotient, signed, truncated toward zero.
- data_exception  output  1  set with data_resultRDY when the divide is invalid.
- data_resultRDY  output  1  one-cycle pulse: result/exception valid.
- busy  output  1  high while a division is in progress.

Behaviour:
- Reset (async, any time): state IDLE. data_result=0, data_exception=0, data_resultRDY=0, busy=0. All internal registers cleared. Any in-flight operation is discarded and no RDY pulse is issued for it.
- States: IDLE, CHECK, ITER, FIX, DONE.
- IDLE: on ctrl_DIV=1 at edge t:
  - latch A and B; record sign_q = A[31]^B[31];
  - latch |A| into the quotient/shift register and |B| into the divisor register;
  - clear the 33-bit remainder; set count=0; go to CHECK; busy=1.
- CHECK (edge t+1):
  - if B==0, or A==0x80000000 with B==0xFFFFFFFF: go to DONE with exception=1, result=0. RDY is high during cycle t+2, i.e. 2-cycle latency.
  - else go to ITER.
- ITER (edges t+2..t+33, ITERS steps):
  - shift {rem,quo} left by 1;
  - trial = rem − divisor (33-bit);
  - if trial non-negative, rem=trial and quo[0]=1, else quo[0]=0;
  - count++; leave ITER when count==ITERS−1 after the step.
- FIX (edge t+34): data_result = sign_q ? −quo : quo. Exception=0. Go to DONE.
- DONE: data_resultRDY=1 for exactly one cycle (cycle after edge t+34, i.e. 35-cycle latency); busy drops with it. Next edge returns to IDLE.
- data_result and data_exception hold their values until the next start or reset.
- |0x80000000| is handled with 33-bit magnitude arithmetic; no spurious overflow (e.g. 0x80000000/2 = 0xC0000000).
- ctrl_DIV while busy (any state except IDLE): abort the current operation and restart with the new operands as if from IDLE at that edge. No RDY is issued for the aborted operation.
- ctrl_DIV in the DONE cycle: the RDY pulse still occurs and the new operation starts on that edge.
- Remainder is computed internally but not output. Its sign follows the dividend.

Decomposition:
- Shared include/package:
  - state encodings (IDLE, CHECK, ITER, FIX, DONE);
  - WIDTH default;
  - INT_MIN and NEG_ONE constants;
  - ITERS counter width = clog2(ITERS).
- One sub-module: div_step, a combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Contains the 33-bit subtractor; the top level holds the FSM and registers.

Test Plan:
- A=7, B=2, pulse ctrl_DIV: result=3, exception=0, RDY exactly 35 cycles after start, single-cycle pulse, busy high throughout.
- Signs: A=−7, B=2 → −3 (0xFFFFFFFD); A=7, B=−2 → −3; A=−7, B=−2 → 3; A=0x80000000, B=2 → 0xC0000000, exception=0.
- Divide by zero: A=100, B=0 → exception=1, result=0, RDY 2 cycles after start. Then A=100, B=10 → result=10, exception=0.
- Overflow: A=0x80000000, B=0xFFFFFFFF → exception=1, result=0, 2-cycle latency. Also A=0x80000000, B=1 → 0x80000000, exception=0.
- Restart: start 1000/3, re-pulse ctrl_DIV with 50/5 at cycle 10 → exactly one RDY, 35 cycles after the second start, result=10.
- Reset: assert reset asynchronously mid-ITER (between clock edges) → all outputs 0 immediately, no RDY afterward. A fresh start of 9/3 → result=3.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds FSM encodings, default width, corner-case operands and the counter-width helper.
package seq_divider_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ITER  = 3'd2,
      S_FIX   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Iteration counter width; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_divider_if.sv
// Command/result bundle between the control unit (master) and the divider (slave).
// ctrl_DIV is a single-cycle start that is always accepted (no ready); data_resultRDY is a one-cycle valid with no backpressure, and busy is status only.
interface seq_divider_if
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy
   );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Shifts {rem,quo} left by one, trial-subtracts the divisor and restores on a negative trial.
module div_step
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH:0]   divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] quo_next
);

   // One guard bit above the remainder so the trial sign is never ambiguous.
   logic [WIDTH+1:0] rem_sh;
   logic [WIDTH+1:0] trial;

   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      trial  = rem_sh - {1'b0, divisor};
      if (!trial[WIDTH+1]) begin
         rem_next = trial[WIDTH:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_sh[WIDTH:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: sign/magnitude split, ITERS restoring steps, sign fix-up.
// A start pulse is honoured in every state, aborting any operation in flight.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ITERS = WIDTH
) (
   input  logic          clock,
   input  logic          reset,
   seq_divider_if.slave  div,
   output state_t        dbg_state
);

   localparam int               CNT_W = cnt_width(ITERS);
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONES  = '1;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sign_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH:0]   divisor_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] result_q;
   logic             exc_q;
   logic             rdy_q;
   logic             busy_q;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo_next;

   // |INT_MIN| wraps to itself, which is the correct unsigned magnitude.
   always_comb begin
      a_mag = div.data_operandA[WIDTH-1] ? (~div.data_operandA + WIDTH'(1)) : div.data_operandA;
      b_mag = div.data_operandB[WIDTH-1] ? (~div.data_operandB + WIDTH'(1)) : div.data_operandB;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (divisor_q),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sign_q    <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         count_q   <= '0;
         result_q  <= '0;
         exc_q     <= 1'b0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else if (div.ctrl_DIV) begin
         state_q   <= S_CHECK;
         a_q       <= div.data_operandA;
         b_q       <= div.data_operandB;
         sign_q    <= div.data_operandA[WIDTH-1] ^ div.data_operandB[WIDTH-1];
         quo_q     <= a_mag;
         rem_q     <= '0;
         divisor_q <= {1'b0, b_mag};
         count_q   <= '0;
         result_q  <= '0;
         exc_q     <= 1'b0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               rdy_q <= 1'b0;
            end
            S_CHECK: begin
               if (b_q == '0 || (a_q == MIN_V && b_q == ONES)) begin
                  result_q <= '0;
                  exc_q    <= 1'b1;
                  rdy_q    <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_DONE;
               end else begin
                  state_q <= S_ITER;
               end
            end
            S_ITER: begin
               rem_q   <= rem_next;
               quo_q   <= quo_next;
               count_q <= count_q + CNT_W'(1);
               if (count_q == CNT_W'(ITERS - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               result_q <= sign_q ? (~quo_q + WIDTH'(1)) : quo_q;
               exc_q    <= 1'b0;
               rdy_q    <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               rdy_q   <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               rdy_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign div.data_result    = result_q;
   assign div.data_exception = exc_q;
   assign div.data_resultRDY = rdy_q;
   assign div.busy           = busy_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scenario tasks with a reference-model scoreboard.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_seq_divider;
   import seq_divider_pkg::*;

   localparam int W     = DEF_WIDTH;
   localparam int EXP_W = W + 1;

   logic   clock = 1'b0;
   logic   reset;
   state_t dbg_state;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W), .ITERS(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .div       (bus.slave),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // scoreboard: {exception, result} plus expected latency in cycles
   logic [EXP_W-1:0] exp_q[$];
   int               lat_q[$];
   int               n_checks = 0;
   int               n_errors = 0;

   bit               obs_seen;
   int               obs_cyc;
   logic [EXP_W-1:0] obs_got;
   int               obs_gaps;
   logic             obs_busy_rdy;
   logic             obs_rdy_after;
   logic [EXP_W-1:0] exp_v;
   int               exp_l;

   function automatic logic [EXP_W-1:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa;
      longint sb;
      longint q;
      logic [63:0] qv;
      if (b == '0 || (a == INT_MIN && b == NEG_ONE)) return {1'b1, {W{1'b0}}};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      qv = q;
      return {1'b0, qv[W-1:0]};
   endfunction

   // driver tasks
   task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [EXP_W-1:0] e;
      @(negedge clock);
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = a;
      bus.data_operandB = b;
      e = model_div(a, b);
      exp_q.push_back(e);
      lat_q.push_back(e[W] ? 2 : W + 3);
   endtask

   task automatic drop_pending();
      if (exp_q.size() > 0) begin
         void'(exp_q.pop_back());
         void'(lat_q.pop_back());
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         bus.ctrl_DIV = 1'b0;
      end
   endtask

   // Collects the next RDY pulse; cycle 1 is the falling edge right after the start edge.
   task automatic wait_rdy(input int max_cycles);
      obs_seen      = 1'b0;
      obs_cyc       = 0;
      obs_got       = '0;
      obs_gaps      = 0;
      obs_busy_rdy  = 1'bx;
      obs_rdy_after = 1'bx;
      while (!obs_seen && obs_cyc < max_cycles) begin
         @(negedge clock);
         bus.ctrl_DIV = 1'b0;
         obs_cyc++;
         if (bus.data_resultRDY === 1'b1) begin
            obs_seen     = 1'b1;
            obs_got      = {bus.data_exception, bus.data_result};
            obs_busy_rdy = bus.busy;
         end else if (bus.busy !== 1'b1) begin
            obs_gaps++;
         end
      end
      if (obs_seen) begin
         @(negedge clock);
         obs_rdy_after = bus.data_resultRDY;
      end
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : {EXP_W{1'bx}};
      exp_l = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
   endtask

   task automatic test_reset();
      reset             = 1'b1;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (dbg_state !== S_IDLE) begin
         n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
      end
      n_checks++;
      if (bus.data_result !== '0) begin
         n_errors++; $display("FAIL reset_result: got %h expected 0", bus.data_result);
      end
      n_checks++;
      if ({bus.data_exception, bus.data_resultRDY, bus.busy} !== 3'b000) begin
         n_errors++; $display("FAIL reset_flags: got exc/rdy/busy=%b expected 000",
                              {bus.data_exception, bus.data_resultRDY, bus.busy});
      end
      reset = 1'b0;
      idle_cycles(2);
   endtask

   task automatic test_basic();
      start_div(32'd7, 32'd2);
      wait_rdy(60);
      n_checks++;
      if (!obs_seen || obs_cyc !== exp_l) begin
         n_errors++; $display("FAIL basic_latency: got %0d (seen=%0b) expected %0d", obs_cyc, obs_seen, exp_l);
      end
      n_checks++;
      if (obs_got !== exp_v) begin
         n_errors++; $display("FAIL basic_result: got %h expected %h", obs_got, exp_v);
      end
      n_checks++;
      if (obs_gaps !== 0) begin
         n_errors++; $display("FAIL basic_busy: busy low in %0d cycles, expected 0", obs_gaps);
      end
      n_checks++;
      if (obs_busy_rdy !== 1'b0 || obs_rdy_after !== 1'b0) begin
         n_errors++; $display("FAIL basic_pulse: busy@rdy=%b rdy_next=%b expected 0 0", obs_busy_rdy, obs_rdy_after);
      end
   endtask

   task automatic test_signs();
      logic [W-1:0] ta[6];
      logic [W-1:0] tb[6];
      ta = '{-32'sd7, 32'd7,  -32'sd7, INT_MIN, INT_MIN, 32'd1000};
      tb = '{32'd2,  -32'sd2, -32'sd2, 32'd2,   32'd1,   -32'sd1};
      for (int i = 0; i < 6; i++) begin
         start_div(ta[i], tb[i]);
         wait_rdy(60);
         n_checks++;
         if (!obs_seen || obs_cyc !== exp_l || obs_got !== exp_v) begin
            n_errors++; $display("FAIL signs_%0d: got %h after %0d expected %h after %0d", i, obs_got, obs_cyc, exp_v, exp_l);
         end
      end
      // fixed anchors independent of the model
      start_div(INT_MIN, 32'd2);
      wait_rdy(60);
      n_checks++;
      if (obs_got !== {1'b0, 32'hC000_0000}) begin
         n_errors++; $display("FAIL signs_intmin_div2: got %h expected 0c0000000", obs_got);
      end
      start_div(-32'sd7, 32'd2);
      wait_rdy(60);
      n_checks++;
      if (obs_got !== {1'b0, 32'hFFFF_FFFD}) begin
         n_errors++; $display("FAIL signs_m7_div2: got %h expected 0fffffffd", obs_got);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int i = 0; i < 8; i++) begin
         a = $urandom >> $urandom_range(0, 31);
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) a = ~a + 32'd1;
         if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
         start_div(a, b);
         wait_rdy(60);
         n_checks++;
         if (!obs_seen || obs_cyc !== exp_l || obs_got !== exp_v) begin
            n_errors++; $display("FAIL random_%0d: %h/%h got %h after %0d expected %h after %0d",
                                 i, a, b, obs_got, obs_cyc, exp_v, exp_l);
         end
      end
   endtask

   task automatic test_exceptions();
      logic [W-1:0] ta[4];
      logic [W-1:0] tb[4];
      int           lat[4];
      logic [W:0]   ev[4];
      ta  = '{32'd100, 32'd100, INT_MIN, INT_MIN};
      tb  = '{32'd0,   32'd10,  NEG_ONE, 32'd1};
      lat = '{2, 35, 2, 35};
      ev  = '{{1'b1, 32'd0}, {1'b0, 32'd10}, {1'b1, 32'd0}, {1'b0, INT_MIN}};
      for (int i = 0; i < 4; i++) begin
         start_div(ta[i], tb[i]);
         wait_rdy(60);
         n_checks++;
         if (!obs_seen || obs_cyc !== lat[i]) begin
            n_errors++; $display("FAIL exc_latency_%0d: got %0d expected %0d", i, obs_cyc, lat[i]);
         end
         n_checks++;
         if (obs_got !== ev[i] || exp_v !== ev[i]) begin
            n_errors++; $display("FAIL exc_result_%0d: got %h expected %h", i, obs_got, ev[i]);
         end
      end
   endtask

   task automatic test_restart();
      int extra;
      start_div(32'd1000, 32'd3);
      idle_cycles(9);
      drop_pending();
      start_div(32'd50, 32'd5);
      wait_rdy(60);
      n_checks++;
      if (!obs_seen || obs_cyc !== 35 || obs_got !== {1'b0, 32'd10}) begin
         n_errors++; $display("FAIL restart: got %h after %0d expected 00000000a after 35", obs_got, obs_cyc);
      end
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus.data_resultRDY === 1'b1) extra++;
      end
      n_checks++;
      if (extra !== 0) begin
         n_errors++; $display("FAIL restart_extra_rdy: got %0d pulses expected 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit seen;
      logic [EXP_W-1:0] got;
      logic [EXP_W-1:0] e;
      start_div(32'd20, 32'd4);
      cyc = 0;
      seen = 1'b0;
      got = '0;
      while (!seen && cyc < 60) begin
         @(negedge clock);
         bus.ctrl_DIV = 1'b0;
         cyc++;
         if (bus.data_resultRDY === 1'b1) begin
            seen = 1'b1;
            got  = {bus.data_exception, bus.data_result};
         end
      end
      e = exp_q.pop_front();
      void'(lat_q.pop_front());
      n_checks++;
      if (!seen || cyc !== 35 || got !== e) begin
         n_errors++; $display("FAIL b2b_first: got %h after %0d expected %h after 35", got, cyc, e);
      end
      // start the next divide in the DONE cycle itself
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = 32'd21;
      bus.data_operandB = -32'sd7;
      exp_q.push_back(model_div(32'd21, -32'sd7));
      lat_q.push_back(35);
      wait_rdy(60);
      n_checks++;
      if (!obs_seen || obs_cyc !== exp_l || obs_got !== exp_v) begin
         n_errors++; $display("FAIL b2b_second: got %h after %0d expected %h after %0d", obs_got, obs_cyc, exp_v, exp_l);
      end
   endtask

   task automatic test_async_reset();
      int extra;
      start_div(32'd1000, 32'd7);
      idle_cycles(10);
      drop_pending();
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.data_result !== '0 || {bus.data_exception, bus.data_resultRDY, bus.busy} !== 3'b000
          || dbg_state !== S_IDLE) begin
         n_errors++; $display("FAIL async_reset: got res=%h exc/rdy/busy=%b state=%0d expected 0 000 0",
                              bus.data_result, {bus.data_exception, bus.data_resultRDY, bus.busy}, dbg_state);
      end
      @(negedge clock);
      reset = 1'b0;
      extra = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (bus.data_resultRDY === 1'b1 || bus.busy === 1'b1) extra++;
      end
      n_checks++;
      if (extra !== 0) begin
         n_errors++; $display("FAIL async_reset_quiet: got %0d active cycles expected 0", extra);
      end
      start_div(32'd9, 32'd3);
      wait_rdy(60);
      n_checks++;
      if (!obs_seen || obs_cyc !== 35 || obs_got !== {1'b0, 32'd3}) begin
         n_errors++; $display("FAIL async_reset_fresh: got %h after %0d expected 000000003 after 35", obs_got, obs_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_random();
      test_exceptions();
      test_restart();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
